mc_controller: RTL
==================

# mc_controller

Multicycle main controller for the MIPS core. It decodes the 6-bit opcode and sequences each instruction through fetch, decode, execute, memory and writeback states. It drives datapath enables and muxes plus the 2-bit `aluop` consumed by the ALU decoder, which turns `aluop` and `funct` into `alucontrol`. Memory accesses use a `memready` handshake, so the controller stalls for slow memory.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `op`  in  6  opcode from instruction register (`instr[31:26]`).
- `zero`  in  1  ALU zero flag.
- `memready`  in  1  memory completes current access this cycle.
- `memread`  out  1  memory read request.
- `memwrite`  out  1  memory write request.
- `irwrite`  out  1  load instruction register.
- `iord`  out  1  0 = address from PC, 1 = from ALUOut.
- `regdst`  out  1  0 = rt, 1 = rd.
- `memtoreg`  out  1  0 = ALUOut, 1 = Data register.
- `regwrite`  out  1  register file write enable.
- `alusrca`  out  1  0 = PC, 1 = register A.
- `alusrcb`  out  2  00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- `pcsrc`  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `pcen`  out  1  PC load; equals `pcwrite | (branch & zero)`.
- `aluop`  out  2  00 = add, 01 = sub, 10 = use funct.
- `illegal`  out  1  one-cycle pulse in DECODE for an unsupported opcode.

## Operation
The state register is 4 bits and resets asynchronously to FETCH. Outputs are decoded from the state. All outputs not listed for a state are 0. While `reset_n` is low, every output is 0.

State encodings and transitions:
- **FETCH (0)**
  - Outputs: `memread`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=00, `pcsrc`=00.
  - `irwrite` and `pcwrite` equal `memready`.
  - Stays in FETCH while `memready`=0; goes to DECODE when `memready`=1.
- **DECODE (1)**
  - Outputs: `alusrca`=0, `alusrcb`=11, `aluop`=00.
  - Next state by opcode:
    - lw 100011 or sw 101011 → MEMADR
    - R-type 000000 → RTYPEEX
    - beq 000100 → BEQEX
    - addi 001000 → ADDIEX
    - j 000010 → JEX
    - anything else → FETCH, with `illegal`=1.
- **MEMADR (2)**
  - Outputs: `alusrca`=1, `alusrcb`=10, `aluop`=00.
  - Goes to MEMRD for lw, MEMWR for sw.
- **MEMRD (3)**
  - Outputs: `memread`=1, `iord`=1.
  - Waits for `memready`, then goes to MEMWB.
- **MEMWB (4)**
  - Outputs: `regdst`=0, `memtoreg`=1, `regwrite`=1.
  - Goes to FETCH.
- **MEMWR (5)**
  - Outputs: `memwrite`=1, `iord`=1.
  - Waits for `memready`, then goes to FETCH.
- **RTYPEEX (6)**
  - Outputs: `alusrca`=1, `alusrcb`=00, `aluop`=10.
  - Goes to RTYPEWB.
- **RTYPEWB (7)**
  - Outputs: `regdst`=1, `memtoreg`=0, `regwrite`=1.
  - Goes to FETCH.
- **BEQEX (8)**
  - Outputs: `alusrca`=1, `alusrcb`=00, `aluop`=01, `pcsrc`=01, `branch`=1.
  - Goes to FETCH.
- **ADDIEX (9)**
  - Outputs: `alusrca`=1, `alusrcb`=10, `aluop`=00.
  - Goes to ADDIWB.
- **ADDIWB (10)**
  - Outputs: `regdst`=0, `memtoreg`=0, `regwrite`=1.
  - Goes to FETCH.
- **JEX (11)**
  - Outputs: `pcsrc`=10, `pcwrite`=1.
  - Goes to FETCH.
- **Codes 12–15:** unreachable; they go to FETCH with all outputs 0.

`op` is sampled only in DECODE and MEMADR. `zero` matters only in BEQEX.

## Timing
- Latency with `memready` held at 1:
  - beq and j: 3 cycles
  - R-type, addi, sw: 4 cycles
  - lw: 5 cycles
- Each cycle with `memready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `memread` and `memwrite` stay asserted and stable until the cycle in which `memready`=1.
- `pcen` is combinational from state and `zero`, with no register stage.
- `illegal` is asserted for exactly one cycle.
- Reset asserted mid-instruction: the state becomes FETCH immediately, asynchronously. No write is issued while `reset_n` is low. The first fetch occurs in the first cycle after `reset_n` rises.

## Configuration
- `MC_JUMP_EN`
  - Defined: opcode 000010 goes to JEX and loads the jump target.
  - Undefined: JEX is not built, and 000010 follows the illegal-opcode path (`illegal`=1, return to FETCH, no PC update beyond the fetch increment).

## Test plan
- Reset: `reset_n` low → all outputs 0. Release with `memready`=1 → `memread`=1, `irwrite`=1, `pcen`=1, `alusrcb`=01 in the first cycle.
- lw, `memready`=1: state sequence 0,1,2,3,4,0. `regwrite`=1 with `memtoreg`=1 and `regdst`=0 in cycle 5.
- sw with `memready` low for 2 cycles in MEMWR: `memwrite` held for 3 cycles, then FETCH. `regwrite` never 1.
- beq, `op`=000100:
  - `zero`=1 → `pcen`=1, `pcsrc`=01, `aluop`=01 in cycle 3.
  - `zero`=0 → `pcen`=0.
- R-type then addi back-to-back: `aluop`=10 in RTYPEEX with `regwrite`/`regdst`=1 in RTYPEWB, then `aluop`=00 and `alusrcb`=10 in ADDIEX.
- `op`=111111 → `illegal` pulses once in DECODE, and the next state is FETCH. `op`=000010 → JEX with `pcsrc`=10 if `MC_JUMP_EN` is defined, `illegal` pulse otherwise. Reset asserted during MEMRD → FETCH with no `regwrite`.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback.
// Optional jump support is built when MC_JUMP_EN is defined.
module mc_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       memready,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [1:0] aluop,
  output logic       illegal
);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MC_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10
`ifdef MC_JUMP_EN
    ,
    S_JEX     = 4'd11
`endif
  } state_t;

  state_t     state, state_nx;
  logic       memread_d, memwrite_d, irwrite_d, iord_d, regdst_d, memtoreg_d;
  logic       regwrite_d, alusrca_d, pcwrite_d, branch_d, illegal_d;
  logic [1:0] alusrcb_d, pcsrc_d, aluop_d;

  // State register; reset forces FETCH immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_nx;
  end

  // Next-state and raw datapath control decode.
  always_comb begin
    state_nx   = S_FETCH;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    irwrite_d  = 1'b0;
    iord_d     = 1'b0;
    regdst_d   = 1'b0;
    memtoreg_d = 1'b0;
    regwrite_d = 1'b0;
    alusrca_d  = 1'b0;
    pcwrite_d  = 1'b0;
    branch_d   = 1'b0;
    illegal_d  = 1'b0;
    alusrcb_d  = 2'b00;
    pcsrc_d    = 2'b00;
    aluop_d    = 2'b00;
    case (state)
      S_FETCH: begin
        memread_d = 1'b1;
        alusrcb_d = 2'b01;
        irwrite_d = memready;
        pcwrite_d = memready;
        state_nx  = memready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb_d = 2'b11;
        case (op)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_RTYPE:     state_nx = S_RTYPEEX;
          OP_BEQ:       state_nx = S_BEQEX;
          OP_ADDI:      state_nx = S_ADDIEX;
`ifdef MC_JUMP_EN
          OP_J:         state_nx = S_JEX;
`endif
          default: begin
            state_nx  = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca_d = 1'b1;
        alusrcb_d = 2'b10;
        // Anything other than lw/sw here means op changed; skip the access.
        if (op == OP_LW)      state_nx = S_MEMRD;
        else if (op == OP_SW) state_nx = S_MEMWR;
        else                  state_nx = S_FETCH;
      end
      S_MEMRD: begin
        memread_d = 1'b1;
        iord_d    = 1'b1;
        state_nx  = memready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg_d = 1'b1;
        regwrite_d = 1'b1;
      end
      S_MEMWR: begin
        memwrite_d = 1'b1;
        iord_d     = 1'b1;
        state_nx   = memready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca_d = 1'b1;
        aluop_d   = 2'b10;
        state_nx  = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst_d   = 1'b1;
        regwrite_d = 1'b1;
      end
      S_BEQEX: begin
        alusrca_d = 1'b1;
        aluop_d   = 2'b01;
        pcsrc_d   = 2'b01;
        branch_d  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca_d = 1'b1;
        alusrcb_d = 2'b10;
        state_nx  = S_ADDIWB;
      end
      S_ADDIWB: regwrite_d = 1'b1;
`ifdef MC_JUMP_EN
      S_JEX: begin
        pcsrc_d   = 2'b10;
        pcwrite_d = 1'b1;
      end
`endif
      default: state_nx = S_FETCH;
    endcase
  end

  // Everything is held at 0 while reset is asserted.
  assign memread  = reset_n & memread_d;
  assign memwrite = reset_n & memwrite_d;
  assign irwrite  = reset_n & irwrite_d;
  assign iord     = reset_n & iord_d;
  assign regdst   = reset_n & regdst_d;
  assign memtoreg = reset_n & memtoreg_d;
  assign regwrite = reset_n & regwrite_d;
  assign alusrca  = reset_n & alusrca_d;
  assign alusrcb  = {2{reset_n}} & alusrcb_d;
  assign pcsrc    = {2{reset_n}} & pcsrc_d;
  assign aluop    = {2{reset_n}} & aluop_d;
  assign illegal  = reset_n & illegal_d;
  assign pcen     = reset_n & (pcwrite_d | (branch_d & zero));

endmodule
